// File: rtl/fix_field_serializer_pkg.sv
// rtl/fix_field_serializer_pkg.sv - shared limits and helpers for the FIX field serializer
package fix_field_serializer_pkg;

   localparam int TAG_MAX_BYTES = 4;

   function automatic logic [2:0] clamp_tag_size(input logic [4:0] size);
      return (size > 5'(TAG_MAX_BYTES)) ? 3'(TAG_MAX_BYTES) : size[2:0];
   endfunction

endpackage

// File: rtl/defines.vh
// rtl/defines.vh - shared FIX protocol character constants and default value width
`ifndef FIX_DEFINES_VH
`define FIX_DEFINES_VH

`define FIX_SOH          8'h01
`define FIX_EQ           8'h3D
`define FIX_ASCII_ZERO   8'h30
`define VALUE_DATA_WIDTH 64

`endif

// File: rtl/fix_checksum_ascii.sv
// rtl/fix_checksum_ascii.sv - 8-bit binary to three zero-padded ASCII decimal digits
`include "defines.vh"

module fix_checksum_ascii (
   input  logic [7:0]  value,
   output logic [23:0] ascii
);

   logic [7:0] hundreds;
   logic [7:0] tens;
   logic [7:0] ones;

   always_comb begin
      hundreds = value / 8'd100;
      tens     = (value / 8'd10) % 8'd10;
      ones     = value % 8'd10;
      ascii    = {`FIX_ASCII_ZERO + hundreds, `FIX_ASCII_ZERO + tens, `FIX_ASCII_ZERO + ones};
   end

endmodule

// File: rtl/fix_field_serializer.sv
// rtl/fix_field_serializer.sv - serializes tag=value<SOH> fields and the trailing checksum field
`include "defines.vh"

module fix_field_serializer
   import fix_field_serializer_pkg::*;
#(
   parameter int VALUE_WIDTH = `VALUE_DATA_WIDTH,
   parameter int SIZE        = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [31:0]            tag_i,
   input  logic                   tag_valid_i,
   input  logic [4:0]             t_size_i,
   input  logic                   checksum_i,
   input  logic [VALUE_WIDTH-1:0] val_i,
   input  logic                   val_valid_i,
   input  logic [SIZE-1:0]        v_size_i,
   output logic [7:0]             byte_o,
   output logic                   byte_valid_o,
   input  logic                   byte_ready_i,
   output logic                   done_o,
   output logic                   end_o,
   output logic [15:0]            msg_len_o,
   output logic                   proto_err_o
);

   localparam int MAXV = VALUE_WIDTH / 8;
   localparam int IDXW = (MAXV > 1) ? $clog2(MAXV) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_TAG, S_EQ, S_WAIT_VAL, S_VAL, S_SOH, S_CK2, S_CK1, S_CK0, S_CKSOH
   } state_t;

   state_t state, state_n;

   logic [31:0]            tag_r;
   logic [1:0]             tidx;
   logic                   ck_flag;
   logic [VALUE_WIDTH-1:0] val_r;
   logic [IDXW-1:0]        vidx;
   logic [7:0]             csum;
   logic [23:0]            ck_ascii;
   logic [2:0]             tsize_c;
   logic [SIZE-1:0]        vsize_c;
   logic [7:0]             tbyte;
   logic [7:0]             vbyte;
   logic                   emitting;
   logic                   xfer;

   assign tsize_c  = clamp_tag_size(t_size_i);
   assign vsize_c  = (v_size_i > SIZE'(MAXV)) ? SIZE'(MAXV) : v_size_i;
   assign emitting = (state != S_IDLE) && (state != S_WAIT_VAL);
   assign xfer     = emitting && byte_ready_i;
   assign tbyte    = tag_r[{tidx, 3'b000} +: 8];

   // Checksum bytes are never accumulated while ck_flag is set, so csum is already frozen here.
   fix_checksum_ascii u_ascii (
      .value (csum),
      .ascii (ck_ascii)
   );

   always_comb begin
      vbyte = 8'h00;
      for (int i = 0; i < MAXV; i++)
         if (vidx == IDXW'(i)) vbyte = val_r[i*8 +: 8];
   end

   always_comb begin
      state_n      = state;
      byte_o       = 8'h00;
      byte_valid_o = emitting;
      case (state)
         S_IDLE:     if (tag_valid_i) state_n = (tsize_c == 3'd0) ? S_EQ : S_TAG;
         S_TAG: begin
            byte_o = tbyte;
            if (byte_ready_i && tidx == 2'd0) state_n = S_EQ;
         end
         S_EQ: begin
            byte_o = `FIX_EQ;
            if (byte_ready_i) state_n = ck_flag ? S_CK2 : S_WAIT_VAL;
         end
         S_WAIT_VAL: if (val_valid_i) state_n = (vsize_c == '0) ? S_SOH : S_VAL;
         S_VAL: begin
            byte_o = vbyte;
            if (byte_ready_i && vidx == '0) state_n = S_SOH;
         end
         S_SOH: begin
            byte_o = `FIX_SOH;
            if (byte_ready_i) state_n = S_IDLE;
         end
         S_CK2: begin
            byte_o = ck_ascii[23:16];
            if (byte_ready_i) state_n = S_CK1;
         end
         S_CK1: begin
            byte_o = ck_ascii[15:8];
            if (byte_ready_i) state_n = S_CK0;
         end
         S_CK0: begin
            byte_o = ck_ascii[7:0];
            if (byte_ready_i) state_n = S_CKSOH;
         end
         S_CKSOH: begin
            byte_o = `FIX_SOH;
            if (byte_ready_i) state_n = S_IDLE;
         end
         default:    state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         tag_r       <= '0;
         tidx        <= '0;
         ck_flag     <= 1'b0;
         val_r       <= '0;
         vidx        <= '0;
         csum        <= '0;
         msg_len_o   <= '0;
         done_o      <= 1'b0;
         end_o       <= 1'b0;
         proto_err_o <= 1'b0;
      end else begin
         state  <= state_n;
         done_o <= xfer && ((state == S_EQ && !ck_flag) || state == S_SOH);
         end_o  <= xfer && (state == S_CKSOH);

         if (state == S_IDLE && tag_valid_i) begin
            tag_r   <= tag_i;
            tidx    <= 2'(tsize_c - 3'd1);
            ck_flag <= checksum_i;
         end else if (state == S_TAG && xfer) begin
            tidx <= tidx - 2'd1;
         end

         if (state == S_WAIT_VAL && val_valid_i) begin
            val_r <= val_i;
            vidx  <= IDXW'(vsize_c - SIZE'(1));
         end else if (state == S_VAL && xfer) begin
            vidx <= vidx - IDXW'(1);
         end

         if (xfer && state == S_CKSOH) begin
            csum      <= '0;
            msg_len_o <= '0;
         end else if (xfer) begin
            if (!ck_flag) csum <= csum + byte_o;
            if (msg_len_o != 16'hFFFF) msg_len_o <= msg_len_o + 16'd1;
         end

         if ((tag_valid_i && state != S_IDLE) || (val_valid_i && state != S_WAIT_VAL))
            proto_err_o <= 1'b1;
      end
   end

endmodule

// File: doc/fix_field_serializer.md
FIX_FIELD_SERIALIZER -- requirements
Module: fix_field_serializer

Interface
REQ-001 SHALL have parameter VALUE_WIDTH, default `VALUE_DATA_WIDTH, value bus width in bits, a multiple of 8; MAXV = VALUE_WIDTH/8.
REQ-002 SHALL have parameter SIZE, default 64, width of value-size input.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 tag_i  in  32  ASCII tag; n chars in tag_i[8n-1:0], first char in the most significant used byte.
REQ-006 tag_valid_i  in  1  one-cycle strobe qualifying tag_i, t_size_i, checksum_i.
REQ-007 t_size_i  in  5  tag length in bytes, 0..4.
REQ-008 checksum_i  in  1  tag is the checksum tag.
REQ-009 val_i  in  VALUE_WIDTH  ASCII value, same alignment rule as tag_i.
REQ-010 val_valid_i  in  1  one-cycle strobe qualifying val_i, v_size_i.
REQ-011 v_size_i  in  SIZE  value length in bytes.
REQ-012 byte_o  out  8  serialized byte.
REQ-013 byte_valid_o  out  1  byte_o valid.
REQ-014 byte_ready_i  in  1  downstream accepts byte; transfer = byte_valid_o && byte_ready_i.
REQ-015 done_o  out  1  one-cycle pulse: field part finished, next item may be presented.
REQ-016 end_o  out  1  one-cycle pulse: message complete.
REQ-017 msg_len_o  out  16  bytes transferred in current message.
REQ-018 proto_err_o  out  1  sticky protocol-error flag.

Function
REQ-019 FSM states: IDLE, TAG, EQ, WAIT_VAL, VAL, SOH, CK2, CK1, CK0, CKSOH.
REQ-020 IDLE: tag_valid_i captures tag/size/flag; go TAG (EQ if t_size_i=0); first byte valid next cycle.
REQ-021 TAG emits t_size_i bytes MSB-first, then EQ emits 8'h3D; t_size_i>4 clamps to 4.
REQ-022 After '=' transfer: non-checksum tag -> done_o pulse next cycle, go WAIT_VAL; checksum tag -> CK2.
REQ-023 WAIT_VAL: val_valid_i captures value, go VAL (SOH if v_size_i=0); v_size_i>MAXV clamps to MAXV.
REQ-024 VAL emits bytes MSB-first, SOH emits 8'h01; after SOH transfer done_o pulses next cycle, go IDLE.
REQ-025 byte_o SHALL hold stable while byte_valid_o && !byte_ready_i; byte_valid_o never drops without a transfer.
REQ-026 8-bit checksum SHALL accumulate every transferred byte mod 256, wrapping, excluding all checksum-tag bytes.
REQ-027 Checksum value frozen at checksum-tag capture; CK2/CK1/CK0 emit hundreds/tens/ones as 8'h30+digit, zero-padded; CKSOH emits 8'h01.
REQ-028 After CKSOH transfer: end_o pulses next cycle, checksum and msg_len_o clear, go IDLE; no done_o.
REQ-029 msg_len_o increments per transfer including checksum field, saturates at 16'hFFFF.
REQ-030 tag_valid_i outside IDLE or val_valid_i outside WAIT_VAL: ignored, proto_err_o set.
REQ-031 Simultaneous tag_valid_i and val_valid_i in IDLE: tag accepted, proto_err_o set.
REQ-032 proto_err_o clears only on rst.

Reset
REQ-033 rst SHALL force IDLE; byte_o=0, byte_valid_o=0, done_o=0, end_o=0, msg_len_o=0, proto_err_o=0, checksum=0, captured registers=0.
REQ-034 rst mid-field SHALL abort immediately; partial field discarded, no done_o/end_o.

Structure
REQ-035 SOH, '=', ASCII '0' constants and VALUE_DATA_WIDTH SHALL live in shared defines.vh; state encoding local.
REQ-036 Binary-to-3-digit-ASCII conversion SHALL be sub-module fix_checksum_ascii (combinational, 8-bit in, 24-bit out).
REQ-037 Value byte select SHALL use a byte index counter, no full-width shift register required.

Verification
REQ-038 tag 16'h3335 size 2, then val 8'h41 size 1, ready=1 -> bytes 33 35 3D, done_o, 41 01, done_o; msg_len_o=5.
REQ-039 continue with tag 16'h3130 size 2 checksum_i=1 -> 31 30 3D 32 33 31 01 (sum 231), end_o pulse, msg_len_o=0 next cycle.
REQ-040 fields totalling byte sum 300 -> checksum digits 30 34 34 ("044").
REQ-041 byte_ready_i low 3 cycles during value byte 2 -> byte_o/byte_valid_o held, no byte lost or duplicated.
REQ-042 rst asserted during VAL -> next cycle byte_valid_o=0, IDLE; new message checksum starts at 0.
REQ-043 val_valid_i in IDLE -> no bytes emitted, proto_err_o=1 until rst.
